bitwise_logic_unit: RTL and testbench



---
 rtl/bitwise_logic_pkg.sv | 26 ++
 rtl/bitwise_logic_unit_if.sv | 32 +++
 rtl/bitwise_logic_unit_logic_slice.sv | 27 ++
 rtl/bitwise_logic_unit.sv | 147 ++++++++++++++
 tb/tb_bitwise_logic_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/bitwise_logic_pkg.sv
// Shared definitions for the bitwise logic unit.
//   op_e     : 2-bit operation encoding carried on the request bus
//   state_e  : sequencing states of the slice-serial datapath
//   cnt_width: width of the slice counter for a given slice count (min 1)
package bitwise_logic_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // A single-slice configuration still needs a 1-bit counter so that the
  // register and its comparisons stay well formed.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitwise_logic_unit_if.sv
// Request/response bus of the bitwise logic unit.
//   in_valid/in_ready  : request handshake, payload op/in1/in2
//   out_valid/out_ready: response handshake, payload result/zero
// modport master: the requester/consumer side
// modport slave : the unit itself
interface bitwise_logic_unit_if
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, op, in1, in2, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, op, in1, in2, out_ready,
    output in_ready, out_valid, result, zero
  );

endinterface

// File: rtl/bitwise_logic_unit_logic_slice.sv
// Combinational per-slice operator shared by every cycle of a RUN phase.
//   a, b : SLICE-bit operand slices
//   op   : operation select
//   y    : SLICE-bit result slice
module logic_slice
  import bitwise_logic_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  op_e              op,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Slice-serial bitwise logic unit.
// A request is captured in IDLE, then one SLICE-wide chunk of the result is
// produced per cycle in RUN (slice 0 first), and the full result is offered
// in DONE until the consumer accepts it.
//   clock   : rising-edge clock
//   reset   : synchronous, active-high reset
//   bus     : slave side of bitwise_logic_unit_if (request + response)
// Parameters: WIDTH operand width, SLICE bits per cycle (WIDTH % SLICE == 0).
module bitwise_logic_unit
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  bitwise_logic_unit_if.slave  bus
);

  localparam int N  = (SLICE > 0) ? (WIDTH / SLICE) : 1;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  generate
    if (SLICE <= 0) begin : g_bad_slice
      $error("bitwise_logic_unit: SLICE must be positive");
    end else if ((WIDTH % SLICE) != 0) begin : g_bad_ratio
      $error("bitwise_logic_unit: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_e           state_reg,  state_next;
  logic [CW-1:0]    cnt_reg,    cnt_next;
  logic [WIDTH-1:0] a_reg,      a_next;
  logic [WIDTH-1:0] b_reg,      b_next;
  op_e              op_reg,     op_next;
  logic [WIDTH-1:0] result_reg, result_next;

  // Captured operands split into slices so the active one can be muxed by
  // the counter without a variable part-select.
  logic [SLICE-1:0] a_slices [N];
  logic [SLICE-1:0] b_slices [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_split
      assign a_slices[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_slices[gi] = b_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_y;

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_reg == CW'(i)) begin
        slice_a = a_slices[i];
        slice_b = b_slices[i];
      end
    end
  end

  // One operator instance, reused for every slice over successive cycles.
  logic_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .op (op_reg),
    .y  (slice_y)
  );

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    op_next     = op_reg;
    result_next = result_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.in1;
          b_next     = bus.in2;
          op_next    = bus.op;
          cnt_next   = '0;
          state_next = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (cnt_reg == CW'(i)) begin
            result_next[i*SLICE +: SLICE] = slice_y;
          end
        end
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      DONE: begin
        // Returning to IDLE (where in_ready rises) rather than accepting here
        // keeps the output handshake and the next acceptance in separate cycles.
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= OP_AND;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      op_reg     <= op_next;
      result_reg <= result_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.result    = result_reg;
  assign bus.zero      = (result_reg == '0);

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed, table-driven bench for bitwise_logic_unit: a 32/8 instance and a
// 16/16 instance share clock and reset.
module tb_bitwise_logic_unit;
  import bitwise_logic_pkg::*;

  logic clock;
  logic reset;

  bitwise_logic_unit_if #(.WIDTH(32)) bus32 ();
  bitwise_logic_unit_if #(.WIDTH(16)) bus16 ();

  bitwise_logic_unit #(.WIDTH(32), .SLICE(8)) dut32 (
    .clock (clock),
    .reset (reset),
    .bus   (bus32)
  );

  bitwise_logic_unit #(.WIDTH(16), .SLICE(16)) dut16 (
    .clock (clock),
    .reset (reset),
    .bus   (bus16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    int          sel;    // 0: 32/8 instance, 1: 16/16 instance
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    int          lat;
    int          hold;   // cycles of out_ready low while out_valid is high
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  function automatic logic in_rdy(input int s);
    return (s == 0) ? bus32.in_ready : bus16.in_ready;
  endfunction

  function automatic logic out_vld(input int s);
    return (s == 0) ? bus32.out_valid : bus16.out_valid;
  endfunction

  function automatic logic [31:0] res_of(input int s);
    return (s == 0) ? bus32.result : {16'h0000, bus16.result};
  endfunction

  function automatic logic zero_of(input int s);
    return (s == 0) ? bus32.zero : bus16.zero;
  endfunction

  task automatic drive(input int s, input logic v, input op_e o,
                       input logic [31:0] a, input logic [31:0] b);
    if (s == 0) begin
      bus32.in_valid = v; bus32.op = o; bus32.in1 = a; bus32.in2 = b;
    end else begin
      bus16.in_valid = v; bus16.op = o; bus16.in1 = a[15:0]; bus16.in2 = b[15:0];
    end
  endtask

  task automatic set_ordy(input int s, input logic v);
    if (s == 0) bus32.out_ready = v;
    else        bus16.out_ready = v;
  endtask

  // One full request/response: accept, latency count, result, optional
  // backpressure, output handshake, return to IDLE.
  task automatic run_txn(input vec_t v);
    int lat;
    logic [31:0] held;
    @(negedge clock);
    drive(v.sel, 1'b1, v.op, v.a, v.b);
    set_ordy(v.sel, 1'b0);
    check({v.name, ".in_ready_idle"}, 32'(in_rdy(v.sel)), 32'd1);
    @(negedge clock);                       // accepting edge passed
    // scramble the inputs: the captured request must be unaffected
    drive(v.sel, 1'b0, OP_NOR, $urandom, $urandom);
    lat = 0;
    while (!out_vld(v.sel) && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check({v.name, ".latency"}, 32'(lat), 32'(v.lat));
    check({v.name, ".result"}, res_of(v.sel), v.res);
    check({v.name, ".zero"}, 32'(zero_of(v.sel)), 32'(v.zero));
    held = res_of(v.sel);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clock);
      check({v.name, ".hold_valid"}, 32'(out_vld(v.sel)), 32'd1);
      check({v.name, ".hold_ready"}, 32'(in_rdy(v.sel)), 32'd0);
      check({v.name, ".hold_result"}, res_of(v.sel), held);
    end
    set_ordy(v.sel, 1'b1);
    @(negedge clock);
    set_ordy(v.sel, 1'b0);
    check({v.name, ".post_valid"}, 32'(out_vld(v.sel)), 32'd0);
    check({v.name, ".post_ready"}, 32'(in_rdy(v.sel)), 32'd1);
    $display("txn %s: op=%s a=0x%h b=0x%h result=0x%h zero=%0b latency=%0d",
             v.name, v.op.name(), v.a, v.b, held, zero_of(v.sel), lat);
  endtask

  initial begin
    int pulses;
    int lat;

    vecs[0] = '{"or32",    0, OP_OR,  32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b0, 4, 0};
    vecs[1] = '{"nor32z",  0, OP_NOR, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 4, 0};
    vecs[2] = '{"xor32z",  0, OP_XOR, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b1, 4, 0};
    vecs[3] = '{"and32bp", 0, OP_AND, 32'h12345678, 32'h0F0F0F0F, 32'h02040608, 1'b0, 4, 5};
    vecs[4] = '{"xor32",   0, OP_XOR, 32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 1'b0, 4, 0};
    vecs[5] = '{"nor32",   0, OP_NOR, 32'h0F0F0F0F, 32'hF0F00000, 32'h0000F0F0, 1'b0, 4, 0};
    vecs[6] = '{"and32",   0, OP_AND, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0, 4, 0};
    vecs[7] = '{"xor16",   1, OP_XOR, 32'h000000FF, 32'h00000F0F, 32'h00000FF0, 1'b0, 1, 0};
    vecs[8] = '{"nor16z",  1, OP_NOR, 32'h0000FFFF, 32'h00000000, 32'h00000000, 1'b1, 1, 2};

    reset = 1'b1;
    drive(0, 1'b0, OP_AND, 32'h0, 32'h0);
    drive(1, 1'b0, OP_AND, 32'h0, 32'h0);
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset%0d.in_ready", s), 32'(in_rdy(s)), 32'd1);
      check($sformatf("reset%0d.out_valid", s), 32'(out_vld(s)), 32'd0);
      check($sformatf("reset%0d.result", s), res_of(s), 32'd0);
      check($sformatf("reset%0d.zero", s), 32'(zero_of(s)), 32'd1);
    end

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Reset on the second RUN cycle discards the request.
    @(negedge clock);
    drive(0, 1'b1, OP_OR, 32'h11223344, 32'h00000000);
    @(negedge clock);                       // accepted; first RUN cycle
    drive(0, 1'b0, OP_AND, 32'h0, 32'h0);
    @(negedge clock);                       // second RUN cycle
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_run.in_ready", 32'(bus32.in_ready), 32'd1);
    check("rst_run.out_valid", 32'(bus32.out_valid), 32'd0);
    check("rst_run.result", bus32.result, 32'd0);
    check("rst_run.zero", 32'(bus32.zero), 32'd1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (bus32.out_valid) pulses++;
    end
    check("rst_run.no_pulse", 32'(pulses), 32'd0);
    $display("txn rst_run: reset in RUN, out_valid pulses afterwards=%0d", pulses);

    // Back-to-back with in_valid and out_ready held high.
    @(negedge clock);
    drive(0, 1'b1, OP_XOR, 32'h0F0F0F0F, 32'hFFFF0000);
    set_ordy(0, 1'b1);
    @(negedge clock);                       // first accept edge passed
    drive(0, 1'b1, OP_OR, 32'h00000001, 32'h80000000);
    lat = 0;
    while (!bus32.out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("b2b.first_latency", 32'(lat), 32'd4);
    check("b2b.first_result", bus32.result, 32'hF0F00F0F);
    @(negedge clock);                       // output handshake edge passed
    check("b2b.no_accept_on_handshake", 32'(bus32.in_ready), 32'd1);
    check("b2b.out_valid_drop", 32'(bus32.out_valid), 32'd0);
    @(negedge clock);                       // second accept edge passed
    check("b2b.second_accept", 32'(bus32.in_ready), 32'd0);
    drive(0, 1'b0, OP_AND, 32'h0, 32'h0);
    lat = 0;
    while (!bus32.out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("b2b.second_latency", 32'(lat), 32'd4);
    check("b2b.second_result", bus32.result, 32'h80000001);
    check("b2b.second_zero", 32'(bus32.zero), 32'd0);
    @(negedge clock);
    set_ordy(0, 1'b0);
    check("b2b.idle", 32'(bus32.in_ready), 32'd1);
    $display("txn b2b: second result=0x%h", 32'h80000001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
